// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: emits round keys 10 down to 0 from the round-10 key with a valid/ready handshake.
// Optional INVKEY_EQINV_EN: rounds 1..9 are emitted as InvMixColumns(key) for the equivalent inverse cipher.
module inv_key_expansion (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] lastKey,
    input  logic         rkReady,
    output logic         rkValid,
    output logic [127:0] roundKey,
    output logic [3:0]   rkRound,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W   = 128;
    localparam int unsigned ROUND_W = 4;
    localparam logic [7:0]  RCON_LAST  = 8'h36;
    localparam logic [3:0]  ROUND_LAST = 4'd10;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [KEY_W-1:0]     block_q, block_d;
    logic [7:0]           rcon_q, rcon_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 rk_valid_q, rk_valid_d;
    logic [KEY_W-1:0]     round_key_q, round_key_d;
    logic [ROUND_W-1:0]   rk_round_q, rk_round_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Entry 0 sits in the top byte of the table, so index with the complement.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One step backwards through the schedule: round r block -> round r-1 block.
    function automatic logic [KEY_W-1:0] prev_block(input logic [KEY_W-1:0] blk, input logic [7:0] rc);
        logic [31:0] a, b, c, d, a_n, b_n, c_n, d_n;
        a   = blk[127:96];
        b   = blk[95:64];
        c   = blk[63:32];
        d   = blk[31:0];
        d_n = d ^ c;
        c_n = c ^ b;
        b_n = b ^ a;
        a_n = a ^ sub_word({d_n[23:0], d_n[31:24]}) ^ {rc, 24'h0};
        return {a_n, b_n, c_n, d_n};
    endfunction

    // Division by x in GF(2^8): walks the round constants backwards.
    function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1b) >> 1) | 8'h80) : (rc >> 1);
    endfunction

`ifdef INVKEY_EQINV_EN
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31 - 8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [KEY_W-1:0] inv_mix(input logic [KEY_W-1:0] blk);
        return {inv_mix_col(blk[127:96]), inv_mix_col(blk[95:64]),
                inv_mix_col(blk[63:32]),  inv_mix_col(blk[31:0])};
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            block_q     <= '0;
            rcon_q      <= RCON_LAST;
            round_q     <= '0;
            rk_valid_q  <= 1'b0;
            round_key_q <= '0;
            rk_round_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            rk_valid_q  <= rk_valid_d;
            round_key_q <= round_key_d;
            rk_round_q  <= rk_round_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and key recurrence; a handshake is the only thing that advances RUN.
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    block_d = lastKey;
                    rcon_d  = RCON_LAST;
                    round_d = ROUND_LAST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rk_valid_q && rkReady) begin
                    if (round_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        block_d = prev_block(block_q, rcon_q);
                        rcon_d  = rcon_prev(rcon_q);
                        round_d = round_q - ROUND_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        rk_valid_d  = (state_d == S_RUN);
        round_key_d = '0;
        rk_round_d  = '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        if (state_d == S_RUN) begin
            round_key_d = block_d;
            rk_round_d  = round_d;
`ifdef INVKEY_EQINV_EN
            if (round_d != '0 && round_d != ROUND_LAST) begin
                round_key_d = inv_mix(block_d);
            end
`endif
        end
    end

    assign rkValid  = rk_valid_q;
    assign roundKey = round_key_q;
    assign rkRound  = rk_round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed self-checking bench for inv_key_expansion using the FIPS-197 key schedule vectors.
module tb_inv_key_expansion;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] lastKey;
    logic         rkReady;
    logic         rkValid;
    logic [127:0] roundKey;
    logic [3:0]   rkRound;
    logic         busy;
    logic         done;

    int total;
    int bad;

    logic [127:0] exp_key  [0:10];
    logic [7:0]   exp_rcon [0:10];

    inv_key_expansion dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lastKey  (lastKey),
        .rkReady  (rkReady),
        .rkValid  (rkValid),
        .roundKey (roundKey),
        .rkRound  (rkRound),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef INVKEY_EQINV_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_ref(input logic [127:0] blk);
        logic [127:0] r;
        logic [7:0]   s0, s1, s2, s3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            s0 = blk[127 - 32*c -: 8];
            s1 = blk[119 - 32*c -: 8];
            s2 = blk[111 - 32*c -: 8];
            s3 = blk[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
            r[119 - 32*c -: 8] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
            r[111 - 32*c -: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
            r[103 - 32*c -: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
        end
        return r;
    endfunction
`endif

    function automatic logic [127:0] exp_out(input int r);
`ifdef INVKEY_EQINV_EN
        if (r >= 1 && r <= 9) return inv_mix_ref(exp_key[r]);
`endif
        return exp_key[r];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [127:0] key);
        lastKey = key;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        rkReady = 1'b1;
        lastKey = '0;
        #1;
        total++;
        if (rkValid !== 1'b0 || roundKey !== 128'h0 || rkRound !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b k=%h r=%0d busy=%b done=%b, want all zero",
                     rkValid, roundKey, rkRound, busy, done);
        end
        step();
        step();
        total++;
        if (dut.rcon_q !== 8'h36) begin
            bad++;
            $display("FAIL reset_rcon: got %h want 36", dut.rcon_q);
        end
        reset = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || rkValid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b v=%b want 0 0", busy, rkValid);
        end
    endtask

    task automatic test_full_sequence();
        int cycles;
        rkReady = 1'b1;
        issue_start(exp_key[10]);
        cycles = 1;
        for (int r = 10; r >= 0; r--) begin
            total++;
            if (rkValid !== 1'b1 || rkRound !== 4'(r) || roundKey !== exp_out(r) || busy !== 1'b1) begin
                bad++;
                $display("FAIL full_round%0d: got v=%b r=%0d k=%h busy=%b want v=1 r=%0d k=%h busy=1",
                         r, rkValid, rkRound, roundKey, busy, r, exp_out(r));
            end
            if (r >= 1) begin
                total++;
                if (dut.rcon_q !== exp_rcon[r]) begin
                    bad++;
                    $display("FAIL rcon_round%0d: got %h want %h", r, dut.rcon_q, exp_rcon[r]);
                end
            end
            step();
            cycles++;
        end
        total++;
        if (done !== 1'b1 || rkValid !== 1'b0 || busy !== 1'b1 || roundKey !== 128'h0 || rkRound !== 4'd0) begin
            bad++;
            $display("FAIL full_done: got done=%b v=%b busy=%b k=%h r=%0d want 1 0 1 0 0",
                     done, rkValid, busy, roundKey, rkRound);
        end
        step();
        cycles++;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || cycles != 13) begin
            bad++;
            $display("FAIL full_idle: got done=%b busy=%b cycles=%0d want 0 0 13", done, busy, cycles);
        end
    endtask

    task automatic test_stall();
        rkReady = 1'b1;
        issue_start(exp_key[10]);
        step();
        step();
        step();
        rkReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (rkValid !== 1'b1 || rkRound !== 4'd7 || roundKey !== exp_out(7)) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b r=%0d k=%h want v=1 r=7 k=%h",
                         i, rkValid, rkRound, roundKey, exp_out(7));
            end
        end
        rkReady = 1'b1;
        for (int r = 7; r >= 0; r--) begin
            total++;
            if (rkValid !== 1'b1 || rkRound !== 4'(r) || roundKey !== exp_out(r)) begin
                bad++;
                $display("FAIL stall_resume%0d: got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                         r, rkValid, rkRound, roundKey, r, exp_out(r));
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: got %b want 1", done);
        end
        step();
    endtask

    task automatic test_start_ignored();
        rkReady = 1'b1;
        issue_start(exp_key[10]);
        for (int i = 0; i < 5; i++) step();
        total++;
        if (rkRound !== 4'd5) begin
            bad++;
            $display("FAIL ign_reach5: got r=%0d want 5", rkRound);
        end
        lastKey = {128{1'b1}};
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int r = 4; r >= 0; r--) begin
            total++;
            if (rkValid !== 1'b1 || rkRound !== 4'(r) || roundKey !== exp_out(r)) begin
                bad++;
                $display("FAIL ign_round%0d: got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                         r, rkValid, rkRound, roundKey, r, exp_out(r));
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ign_done: got %b want 1", done);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        rkReady = 1'b1;
        issue_start(exp_key[10]);
        for (int i = 0; i < 6; i++) step();
        total++;
        if (rkRound !== 4'd4 || rkValid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reach4: got r=%0d v=%b want 4 1", rkRound, rkValid);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (rkValid !== 1'b0 || roundKey !== 128'h0 || rkRound !== 4'd0 || busy !== 1'b0 || done !== 1'b0
            || dut.rcon_q !== 8'h36) begin
            bad++;
            $display("FAIL mid_async_reset: got v=%b k=%h r=%0d busy=%b done=%b rcon=%h want zeros rcon=36",
                     rkValid, roundKey, rkRound, busy, done, dut.rcon_q);
        end
        step();
        reset = 1'b0;
        step();
        issue_start(exp_key[10]);
        for (int r = 10; r >= 0; r--) begin
            total++;
            if (rkValid !== 1'b1 || rkRound !== 4'(r) || roundKey !== exp_out(r)) begin
                bad++;
                $display("FAIL restart_round%0d: got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                         r, rkValid, rkRound, roundKey, r, exp_out(r));
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL restart_done: got %b want 1", done);
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_rcon[0]  = 8'h00;
        exp_rcon[1]  = 8'h01;
        exp_rcon[2]  = 8'h02;
        exp_rcon[3]  = 8'h04;
        exp_rcon[4]  = 8'h08;
        exp_rcon[5]  = 8'h10;
        exp_rcon[6]  = 8'h20;
        exp_rcon[7]  = 8'h40;
        exp_rcon[8]  = 8'h80;
        exp_rcon[9]  = 8'h1b;
        exp_rcon[10] = 8'h36;

        test_reset();
        test_full_sequence();
        test_stall();
        test_start_ignored();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
